fifo_gray_ptr_flag: RTL



---
 rtl/fifo_pkg.sv | 29 ++
 rtl/fifo_gray2bin.sv | 20 ++
 rtl/fifo_gray_ptr_flag.sv | 107 ++++++++++
 3 files changed

// File: rtl/fifo_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_pkg
//  Description : Shared types and helpers for the Gray-pointer FIFO flag logic.
//  Revision    : 1.0 - initial release
// ============================================================================
package fifo_pkg;

    // Which side of the asynchronous FIFO an instance serves.
    typedef enum logic {
        FIFO_SIDE_WR = 1'b0,
        FIFO_SIDE_RD = 1'b1
    } fifo_side_e;

    // Binary to reflected Gray code. Callers truncate to their pointer width;
    // the low bits of the result do not depend on the zero-extended upper bits.
    function automatic logic [31:0] bin2gray(input logic [31:0] bin_val);
        return bin_val ^ (bin_val >> 1);
    endfunction

    // Legal parameter combination: at least 4 entries, and a threshold that
    // stays within the memory depth.
    function automatic bit params_ok(input int addr_bits, input int almost_thresh);
        return (addr_bits >= 2) && (addr_bits <= 30) &&
               (almost_thresh >= 0) && (almost_thresh <= (1 << addr_bits));
    endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_gray2bin.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_gray2bin
//  Description : Combinational Gray to binary converter (XOR prefix from MSB).
//  Revision    : 1.0 - initial release
// ============================================================================
module fifo_gray2bin #(
    parameter int WIDTH = 5
) (
    input  logic [WIDTH-1:0] i_gry,
    output logic [WIDTH-1:0] o_bin
);

    // Each binary bit is the XOR of all Gray bits at and above its position.
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        assign o_bin[i] = ^i_gry[WIDTH-1:i];
    end

endmodule
`default_nettype wire

// File: rtl/fifo_gray_ptr_flag.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_gray_ptr_flag
//  Description : One-side pointer and flag generator for an asynchronous FIFO.
//                Keeps a binary+Gray pointer with wrap bit and derives the
//                full/empty, almost and level outputs against the already
//                synchronised opposite-side Gray pointer.
//  Revision    : 1.0 - initial release
// ============================================================================
module fifo_gray_ptr_flag
    import fifo_pkg::*;
#(
    parameter int         ADDR_BITS     = 4,
    parameter fifo_side_e SIDE          = FIFO_SIDE_WR,
    parameter int         ALMOST_THRESH = 1
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_inc,
    input  logic [ADDR_BITS:0]   i_sync_gry,
    output logic                 o_accept,
    output logic [ADDR_BITS-1:0] o_addr,
    output logic [ADDR_BITS:0]   o_gry,
    output logic                 o_flag,
    output logic                 o_almost,
    output logic [ADDR_BITS:0]   o_level
);

    localparam int c_ptr_w = ADDR_BITS + 1;

    // Level at or above which the writer reports almost-full.
    localparam logic [c_ptr_w-1:0] c_wr_almost_lvl =
        c_ptr_w'((1 << ADDR_BITS) - ALMOST_THRESH);
    // Level at or below which the reader reports almost-empty.
    localparam logic [c_ptr_w-1:0] c_rd_almost_lvl = c_ptr_w'(ALMOST_THRESH);
    // An empty FIFO already counts as almost-full when the margin covers it all.
    localparam logic c_wr_almost_rst = (ALMOST_THRESH >= (1 << ADDR_BITS));

    if (!params_ok(ADDR_BITS, ALMOST_THRESH)) begin : g_param_err
        $error("fifo_gray_ptr_flag: ADDR_BITS or ALMOST_THRESH out of range");
    end

    logic [c_ptr_w-1:0] bin_q,   bin_d;
    logic [c_ptr_w-1:0] gry_q,   gry_d;
    logic [c_ptr_w-1:0] level_q, level_d;
    logic               flag_q,  flag_d;
    logic               almost_q, almost_d;

    logic               w_accept;
    logic [c_ptr_w-1:0] w_rbin;
    logic [c_ptr_w-1:0] w_full_cmp;

    fifo_gray2bin #(
        .WIDTH (c_ptr_w)
    ) u_rbin (
        .i_gry (i_sync_gry),
        .o_bin (w_rbin)
    );

    // A full writer sits exactly one lap ahead: top two Gray bits inverted.
    assign w_full_cmp = {~i_sync_gry[ADDR_BITS:ADDR_BITS-1], i_sync_gry[ADDR_BITS-2:0]};
    assign w_accept   = i_inc & ~flag_q;

    // Next pointer and the flags it would produce against the remote pointer.
    always_comb begin
        bin_d    = bin_q + c_ptr_w'(w_accept);
        gry_d    = c_ptr_w'(bin2gray(32'(bin_d)));
        level_d  = '0;
        flag_d   = 1'b0;
        almost_d = 1'b0;
        if (SIDE == FIFO_SIDE_WR) begin
            level_d  = bin_d - w_rbin;
            flag_d   = (gry_d == w_full_cmp);
            almost_d = (level_d >= c_wr_almost_lvl);
        end else begin
            level_d  = w_rbin - bin_d;
            flag_d   = (gry_d == i_sync_gry);
            almost_d = (level_d <= c_rd_almost_lvl);
        end
    end

    // Pointer and flag registers; reset wins over any request.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            bin_q    <= '0;
            gry_q    <= '0;
            level_q  <= '0;
            flag_q   <= (SIDE == FIFO_SIDE_RD);
            almost_q <= (SIDE == FIFO_SIDE_RD) ? 1'b1 : c_wr_almost_rst;
        end else begin
            bin_q    <= bin_d;
            gry_q    <= gry_d;
            level_q  <= level_d;
            flag_q   <= flag_d;
            almost_q <= almost_d;
        end
    end

    assign o_accept = w_accept;
    assign o_addr   = bin_q[ADDR_BITS-1:0];
    assign o_gry    = gry_q;
    assign o_flag   = flag_q;
    assign o_almost = almost_q;
    assign o_level  = level_q;

endmodule
`default_nettype wire
